serial_to_parallel_receiver: RTL and testbench
==============================================

// Module: serial_to_parallel_receiver
// PURPOSE
//  Receive end of the serial stream produced by the 8-bit parallel-load shifter: samples one bit per
//  qualified CLK edge and reassembles WIDTH-bit words. Supports MSB-first (left-shift source) and
//  LSB-first (right-shift source) framing. Presents completed words on a one-entry valid/ready output.
// PARAMETERS
//  WIDTH   8                   word width in bits; legal range 2..32
//  CNT_W   $clog2(WIDTH)       bit-counter width; derived, never overridden
// PORTS
//  CLK         in   1       rising-edge clock
//  RST_N       in   1       synchronous active-low reset
//  sin         in   1       serial data bit
//  sin_valid   in   1       sin is sampled this cycle; no back-pressure on the serial side
//  dir         in   1       0 = MSB-first (shift left in), 1 = LSB-first (shift right in)
//  clear       in   1       abort the partial word; counter and shift reg return to 0
//  dout        out  WIDTH   assembled word
//  dout_valid  out  1       dout holds an unconsumed word
//  dout_ready  in   1       consumer accepts dout when dout_valid & dout_ready
//  bit_cnt     out  CNT_W   bits collected in the current partial word
//  overrun     out  1       sticky: a completed word was dropped; cleared by clear or reset
// BEHAVIOUR
//  - Reset (RST_N=0 at CLK edge): shift reg, bit_cnt, dout = 0; dout_valid = 0; overrun = 0; dir_q = 0.
//  - Direction latched into dir_q when a bit is accepted with bit_cnt==0; dir changes mid-word are
//    ignored until the next word starts.
//  - Accepted bit, dir_q=0: sreg <= {sreg[WIDTH-2:0], sin}. dir_q=1: sreg <= {sin, sreg[WIDTH-1:1]}.
//  - bit_cnt increments per accepted bit; on the WIDTH-th bit it wraps to 0 and the word completes.
//    The completed word is the shifted value including that bit (not the stale sreg).
//  - Completion latency: dout/dout_valid update on the same edge that samples the last bit, so
//    dout_valid is high in the cycle after the WIDTH-th sin_valid.
//  - Output register: handshake fires when dout_valid & dout_ready; dout_valid falls the next cycle
//    unless a new word completes on that same edge (back-to-back: dout replaced, dout_valid stays 1).
//  - Completion while dout_valid=1 and dout_ready=0: new word discarded, dout unchanged, overrun <= 1.
//  - dout holds its last value when dout_valid=0; dout_ready is ignored while dout_valid=0.
//  - clear: bit_cnt, sreg <= 0, overrun <= 0 on that edge; output register (dout, dout_valid) unaffected.
//    clear together with sin_valid: clear wins, the bit is discarded, no completion.
//  - Reset mid-word or with dout_valid=1: everything, including the pending output word, is dropped.
//  - sin_valid=0: no state change except the output handshake.
//  - Throughput: one word per WIDTH cycles sustained with dout_ready tied high; zero drops.
// STRUCTURE
//  - Package shift_pkg: typedef enum logic {DIR_MSB_FIRST=1'b0, DIR_LSB_FIRST=1'b1} shift_dir_e;
//    localparam int SHIFT_WIDTH_DEFAULT = 8. Shared with the shifter's bench and future framing blocks.
//  - Sub-module word_hold_reg (WIDTH): one-entry valid/ready holding register with load, drop and
//    overrun detection; top level holds the counter, direction latch and shift register.
//  - All state in one always_ff on posedge CLK; no latches, no async paths.
// TESTING
//  - Reset: RST_N=0 two cycles with random sin/sin_valid -> dout=0, dout_valid=0, bit_cnt=0, overrun=0.
//  - MSB-first: dir=0, bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> dout=8'hA5, dout_valid=1 next cycle.
//  - LSB-first: dir=1, same bit sequence -> dout=8'hA5 reversed = 8'hA5? no: use 1,0,0,0,0,0,0,0 -> dout=8'h01;
//    dir=0 with the same sequence -> dout=8'h80.
//  - Dir latch: dir=0 for bit 0, dir flipped to 1 for bits 1..7 of 8'hC3 stream -> dout=8'hC3 (MSB-first).
//  - Overrun: dout_ready=0, stream 8'h11 then 8'h22 -> dout=8'h11, overrun=1; then dout_ready=1 ->
//    dout_valid falls; clear -> overrun=0.
//  - Clear/gaps: 3 bits, clear with sin_valid=1 -> bit_cnt=0, that bit dropped; 8'h5A sent with idle
//    gaps between bits -> dout=8'h5A; back-to-back 8'h01,8'h02 with dout_ready=1 -> both seen, no overrun.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shift direction encoding and default word width shared by shifter-side blocks
package shift_pkg;
  typedef enum logic {DIR_MSB_FIRST = 1'b0, DIR_LSB_FIRST = 1'b1} shift_dir_e;
  localparam int SHIFT_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/word_hold_reg.sv
// word_hold_reg: one-entry valid/ready output register that drops words arriving while full and flags overrun
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovr,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);
  logic [WIDTH-1:0] dout_q, dout_d;
  logic valid_q, valid_d, ovr_q, ovr_d, fire, take;
  always_comb begin
    fire = valid_q & dout_ready;
    take = load & (~valid_q | fire);
    dout_d = take ? din : dout_q;
    valid_d = take | (valid_q & ~fire);
    ovr_d = clr_ovr ? 1'b0 : (ovr_q | (load & ~take));
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dout_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  end
  assign dout = dout_q;
  assign dout_valid = valid_q;
  assign overrun = ovr_q;
endmodule

// File: rtl/serial_to_parallel_receiver.sv
// serial_to_parallel_receiver: reassembles MSB- or LSB-first serial bits into words on a valid/ready output
module serial_to_parallel_receiver
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH_DEFAULT,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);
  logic [WIDTH-1:0] sreg_q, sreg_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  shift_dir_e dir_q, dir_d, dir_use;
  logic accept, last;
  // direction is taken live on the first bit of a word, then held for the rest of it
  always_comb begin
    accept = sin_valid & ~clear;
    last = cnt_q == CNT_W'(WIDTH - 1);
    dir_use = (cnt_q == '0) ? shift_dir_e'(dir) : dir_q;
    shifted = (dir_use == DIR_LSB_FIRST) ? {sin, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], sin};
    dir_d = accept ? dir_use : dir_q;
    sreg_d = clear ? '0 : accept ? shifted : sreg_q;
    cnt_d = clear ? '0 : accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sreg_q <= '0;
      cnt_q <= '0;
      dir_q <= DIR_MSB_FIRST;
    end else begin
      sreg_q <= sreg_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end
  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load      (accept & last),
    .din       (shifted),
    .clr_ovr   (clear),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overrun   (overrun)
  );
  assign bit_cnt = cnt_q;
endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// tb_serial_to_parallel_receiver: directed scenario tests for the serial-to-parallel receiver
module tb_serial_to_parallel_receiver;
  logic CLK = 1'b0, RST_N = 1'b0, sin = 1'b0, sin_valid = 1'b0, dir = 1'b0, clear = 1'b0, dout_ready = 1'b0;
  logic [7:0] dout;
  logic dout_valid, overrun;
  logic [2:0] bit_cnt;
  int checks = 0, errors = 0;
  serial_to_parallel_receiver #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .sin(sin), .sin_valid(sin_valid), .dir(dir), .clear(clear),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .bit_cnt(bit_cnt), .overrun(overrun)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send_seq(input logic [7:0] bits, input logic d);
    for (int i = 7; i >= 0; i--) begin
      sin = bits[i];
      sin_valid = 1'b1;
      dir = d;
      tick();
    end
    sin_valid = 1'b0;
  endtask
  task automatic test_reset();
    RST_N = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sin = 1'($urandom);
      sin_valid = 1'($urandom);
      tick();
    end
    sin_valid = 1'b0;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d exp 0", bit_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    RST_N = 1'b1;
    tick();
  endtask
  task automatic test_msb_first();
    dout_ready = 1'b1;
    send_seq(8'hA5, 1'b0);
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL msb_dout got %h exp a5", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL msb_valid got %b exp 1", dout_valid); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL msb_bit_cnt got %0d exp 0", bit_cnt); end
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL msb_consumed got %b exp 0", dout_valid); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL msb_hold got %h exp a5", dout); end
  endtask
  task automatic test_lsb_first();
    send_seq(8'h80, 1'b1);
    checks++; if (dout !== 8'h01) begin errors++; $display("FAIL lsb_dout got %h exp 01", dout); end
    tick();
    send_seq(8'h80, 1'b0);
    checks++; if (dout !== 8'h80) begin errors++; $display("FAIL lsb_vs_msb_dout got %h exp 80", dout); end
    tick();
  endtask
  task automatic test_dir_latch();
    logic [7:0] w = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      sin = w[i];
      sin_valid = 1'b1;
      dir = (i == 7) ? 1'b0 : 1'b1;
      tick();
    end
    sin_valid = 1'b0;
    dir = 1'b0;
    checks++; if (dout !== 8'hC3) begin errors++; $display("FAIL dir_latch_dout got %h exp c3", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL dir_latch_valid got %b exp 1", dout_valid); end
    tick();
  endtask
  task automatic test_overrun();
    dout_ready = 1'b0;
    send_seq(8'h11, 1'b0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_word got %b exp 0", overrun); end
    send_seq(8'h22, 1'b0);
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL ovr_dout got %h exp 11", dout); end
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", dout_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    dout_ready = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b exp 0", dout_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL ovr_clear_dout got %h exp 11", dout); end
  endtask
  task automatic test_clear_gaps();
    logic [7:0] w = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      sin = 1'b1;
      sin_valid = 1'b1;
      tick();
    end
    checks++; if (bit_cnt !== 3'd3) begin errors++; $display("FAIL clr_partial_cnt got %0d exp 3", bit_cnt); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    sin_valid = 1'b0;
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL clr_bit_cnt got %0d exp 0", bit_cnt); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL clr_no_word got %b exp 0", dout_valid); end
    for (int i = 7; i >= 0; i--) begin
      sin = w[i];
      sin_valid = 1'b1;
      dir = 1'b0;
      tick();
      sin_valid = 1'b0;
      sin = ~sin;
      tick();
      if (i == 4) begin
        checks++; if (bit_cnt !== 3'd4) begin errors++; $display("FAIL gap_bit_cnt got %0d exp 4", bit_cnt); end
      end
    end
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL gap_dout got %h exp 5a", dout); end
    tick();
  endtask
  task automatic test_back_to_back();
    dout_ready = 1'b1;
    send_seq(8'h01, 1'b0);
    checks++; if (dout !== 8'h01 || dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b exp 01/1", dout, dout_valid); end
    send_seq(8'h02, 1'b0);
    checks++; if (dout !== 8'h02 || dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b exp 02/1", dout, dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
    dout_ready = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sin = 1'(8'h3C >> i);
      sin_valid = 1'b1;
      dout_ready = (i == 0);
      tick();
    end
    sin_valid = 1'b0;
    dout_ready = 1'b0;
    checks++; if (dout !== 8'h3C || dout_valid !== 1'b1) begin errors++; $display("FAIL replace_word got %h/%b exp 3c/1", dout, dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL replace_overrun got %b exp 0", overrun); end
    dout_ready = 1'b1;
    tick();
  endtask
  task automatic test_reset_mid_word();
    dout_ready = 1'b0;
    send_seq(8'h77, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sin = 1'b1;
      sin_valid = 1'b1;
      tick();
    end
    RST_N = 1'b0;
    tick();
    sin_valid = 1'b0;
    checks++; if (dout !== 8'h00 || dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out got %h/%b exp 00/0", dout, dout_valid); end
    checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d exp 0", bit_cnt); end
    RST_N = 1'b1;
    dout_ready = 1'b1;
    tick();
    send_seq(8'h0F, 1'b0);
    checks++; if (dout !== 8'h0F) begin errors++; $display("FAIL rst_mid_next got %h exp 0f", dout); end
  endtask
  initial begin
    tick();
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_dir_latch();
    test_overrun();
    test_clear_gaps();
    test_back_to_back();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
